// File: rtl/retire_port_arbiter_pkg.sv
// Shared configuration and types for the retire-port arbiter slice.
package retire_port_arbiter_pkg;

  localparam int NUM_UNITS    = 4;                  // multi-cycle writeback requesters
  localparam int NUM_WB_UNITS = NUM_UNITS;
  localparam int COMMIT_PORTS = 3;                  // port 0 is the issue-time path
  localparam int SHARED       = COMMIT_PORTS - 1;   // ports shared by the units
  localparam int ID_W         = 3;
  localparam int DATA_W       = 32;
  localparam int CNT_W        = 2;                  // wide enough to hold COMMIT_PORTS
  localparam int PTR_W        = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  typedef logic [ID_W-1:0]   id_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [PTR_W-1:0]  ptr_t;

  typedef struct packed {
    id_t   id;
    data_t data;
  } wb_request_t;

endpackage

// File: rtl/retire_port_arbiter_if.sv
// Writeback-to-commit bundle: requests in, acks and registered commit ports out.
interface retire_port_arbiter_if;
  import retire_port_arbiter_pkg::*;

  logic                        fast_valid;
  id_t                         fast_id;
  data_t                       fast_data;
  logic  [NUM_UNITS-1:0]       unit_valid;
  id_t   [NUM_UNITS-1:0]       unit_id;
  data_t [NUM_UNITS-1:0]       unit_data;
  logic  [NUM_UNITS-1:0]       unit_ack;
  logic  [COMMIT_PORTS-1:0]    retired;
  id_t   [COMMIT_PORTS-1:0]    ids_retiring;
  data_t [COMMIT_PORTS-1:0]    retired_data;
  logic  [CNT_W-1:0]           retire_count;

  // Writeback side: presents completions, consumes acks and commit ports.
  modport master (
    output fast_valid, fast_id, fast_data, unit_valid, unit_id, unit_data,
    input  unit_ack, retired, ids_retiring, retired_data, retire_count
  );

  // Arbiter side.
  modport slave (
    input  fast_valid, fast_id, fast_data, unit_valid, unit_id, unit_data,
    output unit_ack, retired, ids_retiring, retired_data, retire_count
  );

endinterface

// File: rtl/retire_port_arbiter_picker.sv
// Rotating-priority multi-grant picker: grants up to SHARED requesters,
// scanning from rr_ptr upward with wrap.
module retire_port_arbiter_picker
  import retire_port_arbiter_pkg::*;
(
  input  logic [NUM_UNITS-1:0]             req_i,
  input  ptr_t                             rr_ptr_i,
  output logic [SHARED-1:0][NUM_UNITS-1:0] grant_o,
  output logic [NUM_UNITS-1:0]             ack_o,
  output logic                             any_grant_o,
  output ptr_t                             last_idx_o
);

  localparam logic [NUM_UNITS-1:0] ONE   = NUM_UNITS'(1);
  localparam logic [PTR_W:0]       N_EXT = (PTR_W+1)'(NUM_UNITS);

  logic [2*NUM_UNITS-1:0] req_dbl;
  logic [2*NUM_UNITS-1:0] back_dbl;
  logic [NUM_UNITS-1:0]   remain;
  logic [NUM_UNITS-1:0]   pick;
  logic [PTR_W:0]         last_rot;
  logic [PTR_W:0]         last_sum;

  // Rotate requests so rr_ptr is bit 0, peel off the lowest set bit SHARED
  // times, and rotate each pick back into unit numbering.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that leaves one unassigned infers a latch.
    grant_o     = '0;
    ack_o       = '0;
    any_grant_o = 1'b0;
    last_rot    = '0;
    back_dbl    = '0;
    pick        = '0;
    req_dbl     = {req_i, req_i} >> rr_ptr_i;
    remain      = req_dbl[NUM_UNITS-1:0];
    for (int k = 0; k < SHARED; k++) begin
      pick       = remain & (~remain + ONE);
      remain     = remain & (remain - ONE);
      back_dbl   = {pick, pick} << rr_ptr_i;
      grant_o[k] = back_dbl[2*NUM_UNITS-1:NUM_UNITS];
      ack_o      = ack_o | grant_o[k];
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (pick[i]) last_rot = (PTR_W+1)'(i);
      end
    end
    any_grant_o = |ack_o;
    last_sum    = last_rot + {1'b0, rr_ptr_i};
    if (last_sum >= N_EXT) last_sum = last_sum - N_EXT;
    last_idx_o  = last_sum[PTR_W-1:0];
  end

endmodule

// File: rtl/retire_port_arbiter.sv
// Commit-port scheduler: port 0 mirrors the issue-time path, the remaining
// ports are shared by the multi-cycle units under rotating priority.
module retire_port_arbiter
  import retire_port_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  retire_port_arbiter_if.slave bus
);

  logic [SHARED-1:0][NUM_UNITS-1:0] grant;
  logic [NUM_UNITS-1:0]             pick_ack;
  logic                             any_grant;
  ptr_t                             last_idx;
  ptr_t                             rr_ptr_q, rr_ptr_d;
  logic [COMMIT_PORTS-1:0]          retired_q, retired_d;
  wb_request_t [COMMIT_PORTS-1:0]   port_q, port_d;
  logic [CNT_W-1:0]                 count_q, count_d;
  wb_request_t [NUM_UNITS-1:0]      req;

  retire_port_arbiter_picker u_picker (
    .req_i       (bus.unit_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .ack_o       (pick_ack),
    .any_grant_o (any_grant),
    .last_idx_o  (last_idx)
  );

  // Requests seen during reset must not be consumed.
  assign bus.unit_ack = rst_n ? pick_ack : '0;

  // Next commit-port contents, popcount and priority pointer.
  always_comb begin
    retired_d = '0;
    port_d    = port_q;
    count_d   = '0;
    rr_ptr_d  = rr_ptr_q;
    for (int u = 0; u < NUM_UNITS; u++) begin
      req[u].id   = bus.unit_id[u];
      req[u].data = bus.unit_data[u];
    end
    retired_d[0]    = bus.fast_valid;
    port_d[0].id    = bus.fast_id;
    port_d[0].data  = bus.fast_data;
    for (int k = 0; k < SHARED; k++) begin
      retired_d[k+1] = |grant[k];
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (grant[k][u]) port_d[k+1] = req[u];
      end
    end
    for (int p = 0; p < COMMIT_PORTS; p++) begin
      count_d = count_d + CNT_W'(retired_d[p]);
    end
    if (any_grant) begin
      rr_ptr_d = (last_idx == ptr_t'(NUM_UNITS-1)) ? '0 : last_idx + ptr_t'(1);
    end
  end

  // Output and pointer registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q <= '0;
      port_q    <= '0;
      count_q   <= '0;
      rr_ptr_q  <= '0;
    end else begin
      retired_q <= retired_d;
      port_q    <= port_d;
      count_q   <= count_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // Drive the registered commit ports.
  always_comb begin
    bus.retired      = retired_q;
    bus.retire_count = count_q;
    for (int p = 0; p < COMMIT_PORTS; p++) begin
      bus.ids_retiring[p] = port_q[p].id;
      bus.retired_data[p] = port_q[p].data;
    end
  end

  a_ack_has_valid: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.unit_ack & ~bus.unit_valid) == '0);

  a_ack_limit: assert property (@(posedge clk) disable iff (!rst_n)
    $countones(bus.unit_ack) <= SHARED);

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_stable
    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (bus.unit_valid[u] && !bus.unit_ack[u]) |=>
      (bus.unit_valid[u] && bus.unit_id[u] == $past(bus.unit_id[u])));
  end

  for (genvar i = 0; i < COMMIT_PORTS; i++) begin : g_dup_i
    for (genvar j = i + 1; j < COMMIT_PORTS; j++) begin : g_dup_j
      a_no_dup_id: assert property (@(posedge clk) disable iff (!rst_n)
        !(retired_q[i] && retired_q[j] && port_q[i].id == port_q[j].id));
    end
  end

endmodule

// File: tb/tb_retire_port_arbiter.sv
// Self-checking bench for retire_port_arbiter against a queue-based model.
module tb_retire_port_arbiter;
  import retire_port_arbiter_pkg::*;

  localparam int PW = ID_W + DATA_W;
  typedef logic [COMMIT_PORTS*PW-1:0] payload_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  retire_port_arbiter_if bus ();
  retire_port_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state.
  int m_ptr = 0;
  int grants[$];
  logic [COMMIT_PORTS-1:0] e_ret;
  id_t   e_id   [COMMIT_PORTS];
  data_t e_data [COMMIT_PORTS];
  logic [CNT_W-1:0] e_cnt;

  // Walk units starting at m_ptr; the first SHARED valid ones win.
  function automatic logic [NUM_UNITS-1:0] model_ack();
    logic [NUM_UNITS-1:0] a = '0;
    grants = {};
    if (rst_n) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        int u = (m_ptr + i) % NUM_UNITS;
        if (bus.unit_valid[u] && grants.size() < SHARED) begin
          grants.push_back(u);
          a[u] = 1'b1;
        end
      end
    end
    return a;
  endfunction

  // Advance the model with the current inputs, then clock the DUT.
  task automatic tick();
    logic [NUM_UNITS-1:0] a;
    a = model_ack();
    if (!rst_n) begin
      e_ret = '0; e_cnt = '0; m_ptr = 0;
      for (int p = 0; p < COMMIT_PORTS; p++) begin e_id[p] = '0; e_data[p] = '0; end
    end else begin
      e_ret[0] = bus.fast_valid; e_id[0] = bus.fast_id; e_data[0] = bus.fast_data;
      for (int k = 0; k < SHARED; k++) begin
        if (k < grants.size()) begin
          e_ret[k+1]  = 1'b1;
          e_id[k+1]   = bus.unit_id[grants[k]];
          e_data[k+1] = bus.unit_data[grants[k]];
        end else begin
          e_ret[k+1] = 1'b0;
        end
      end
      e_cnt = CNT_W'($countones(e_ret));
      if (grants.size() > 0) m_ptr = (grants[grants.size()-1] + 1) % NUM_UNITS;
    end
    @(posedge clk); #1;
  endtask

  function automatic payload_t act_payload();
    payload_t v = '0;
    for (int p = 0; p < COMMIT_PORTS; p++)
      if (bus.retired[p]) v[p*PW +: PW] = {bus.ids_retiring[p], bus.retired_data[p]};
    return v;
  endfunction

  function automatic payload_t exp_payload();
    payload_t v = '0;
    for (int p = 0; p < COMMIT_PORTS; p++)
      if (e_ret[p]) v[p*PW +: PW] = {e_id[p], e_data[p]};
    return v;
  endfunction

  task automatic drive_idle();
    bus.fast_valid = 1'b0; bus.fast_id = '0; bus.fast_data = '0;
    bus.unit_valid = '0;   bus.unit_id = '0; bus.unit_data = '0;
  endtask

  task automatic drive_all_valid();
    for (int u = 0; u < NUM_UNITS; u++) begin
      bus.unit_id[u]   = id_t'(4 + u);
      bus.unit_data[u] = $urandom;
    end
    bus.unit_valid = '1;
  endtask

  task automatic new_req(input int u);
    bus.unit_id[u]    = id_t'(u * 2 + int'($urandom % 2));
    bus.unit_data[u]  = $urandom;
    bus.unit_valid[u] = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; drive_idle(); drive_all_valid();
    for (int c = 0; c < 2; c++) begin
      #1; tests_run++;
      if (bus.unit_ack !== '0) begin
        tests_failed++; $display("FAIL reset_ack: got %b expected 0000", bus.unit_ack);
      end
      tick(); tests_run++;
      if ({bus.retired, bus.retire_count, bus.ids_retiring, bus.retired_data} !== '0) begin
        tests_failed++;
        $display("FAIL reset_outputs: retired %b count %0d ids %h data %h expected all zero",
                 bus.retired, bus.retire_count, bus.ids_retiring, bus.retired_data);
      end
    end
    rst_n = 1'b1; #1; tests_run++;
    if (bus.unit_ack !== 4'b0011) begin
      tests_failed++; $display("FAIL reset_release_ack: got %b expected 0011", bus.unit_ack);
    end
    tick(); tests_run++;
    if ({bus.retired, bus.retire_count, act_payload()} !== {e_ret, e_cnt, exp_payload()}) begin
      tests_failed++; $display("FAIL reset_release_out: retired %b count %0d expected %b %0d",
                               bus.retired, bus.retire_count, e_ret, e_cnt);
    end
  endtask

  task automatic test_all_valid();
    logic [NUM_UNITS-1:0] pat [3] = '{4'b0011, 4'b1100, 4'b0011};
    id_t lo_id;
    do_reset(); drive_idle(); drive_all_valid();
    for (int c = 0; c < 3; c++) begin
      #1; tests_run++;
      if (bus.unit_ack !== pat[c]) begin
        tests_failed++; $display("FAIL all_valid_ack%0d: got %b expected %b", c, bus.unit_ack, pat[c]);
      end
      tick(); tests_run++;
      lo_id = (c % 2 == 0) ? id_t'(4) : id_t'(6);
      if ({bus.retired[2:1], bus.retire_count, bus.ids_retiring[1], bus.ids_retiring[2]} !==
          {2'b11, 2'd2, lo_id, id_t'(lo_id + 1)} || act_payload() !== exp_payload()) begin
        tests_failed++;
        $display("FAIL all_valid_out%0d: retired %b count %0d ids %0d/%0d expected ids %0d/%0d",
                 c, bus.retired, bus.retire_count, bus.ids_retiring[1], bus.ids_retiring[2],
                 lo_id, lo_id + 1);
      end
    end
  endtask

  task automatic test_single_wrap();
    do_reset(); drive_idle();
    bus.unit_valid = 4'b1000; bus.unit_id[3] = 3'd2; bus.unit_data[3] = 32'h1234_5678;
    #1; tests_run++;
    if (bus.unit_ack !== 4'b1000) begin
      tests_failed++; $display("FAIL single_ack: got %b expected 1000", bus.unit_ack);
    end
    tick(); tests_run++;
    if ({bus.retired, bus.ids_retiring[1], bus.retired_data[1], bus.retire_count} !==
        {3'b010, 3'd2, 32'h1234_5678, 2'd1}) begin
      tests_failed++; $display("FAIL single_out: retired %b id %0d count %0d expected 010 2 1",
                               bus.retired, bus.ids_retiring[1], bus.retire_count);
    end
    drive_all_valid();
    #1; tests_run++;
    if (bus.unit_ack !== 4'b0011) begin
      tests_failed++; $display("FAIL ptr_wrap_ack: got %b expected 0011", bus.unit_ack);
    end
    tick();
  endtask

  task automatic test_fast_plus_shared();
    do_reset(); drive_idle();
    bus.fast_valid = 1'b1; bus.fast_id = 3'd1; bus.fast_data = 32'h0000_DEAD;
    bus.unit_valid = 4'b0110;
    bus.unit_id[1] = 3'd5; bus.unit_data[1] = 32'hAAAA_0001;
    bus.unit_id[2] = 3'd6; bus.unit_data[2] = 32'hBBBB_0002;
    #1; tests_run++;
    if (bus.unit_ack !== 4'b0110) begin
      tests_failed++; $display("FAIL fast_shared_ack: got %b expected 0110", bus.unit_ack);
    end
    tick(); tests_run++;
    if ({bus.retired, bus.retire_count, bus.ids_retiring, bus.retired_data} !==
        {3'b111, 2'd3, 3'd6, 3'd5, 3'd1, 32'hBBBB_0002, 32'hAAAA_0001, 32'h0000_DEAD}) begin
      tests_failed++;
      $display("FAIL fast_shared_out: retired %b count %0d ids %h data0 %h expected 111 3 ids 6/5/1 data0 dead",
               bus.retired, bus.retire_count, bus.ids_retiring, bus.retired_data[0]);
    end
  endtask

  // Units 0 and 2 re-request every cycle; unit 1 idles one cycle after each ack.
  // With random_mode, every unit re-requests at random and the fast path fires at random.
  task automatic test_traffic(input string name, input int cycles, input bit random_mode);
    int waited [NUM_UNITS];
    logic [NUM_UNITS-1:0] a;
    logic [NUM_UNITS-1:0] e;
    bit clash;
    do_reset(); drive_idle();
    for (int u = 0; u < NUM_UNITS; u++) begin
      waited[u] = 0;
      if (!random_mode && u != 3) new_req(u);
    end
    for (int c = 0; c < cycles; c++) begin
      #1; e = model_ack(); a = bus.unit_ack; tests_run++;
      if (a !== e) begin
        tests_failed++; $display("FAIL %s_ack c%0d: got %b expected %b", name, c, a, e);
      end
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (bus.unit_valid[u] && !a[u]) waited[u]++;
        else waited[u] = 0;
        if (waited[u] >= 2) begin
          tests_failed++; $display("FAIL %s_fair c%0d: unit %0d waited %0d expected < 2", name, c, u, waited[u]);
        end
      end
      tick(); tests_run++;
      if ({bus.retired, bus.retire_count, act_payload()} !== {e_ret, e_cnt, exp_payload()}) begin
        tests_failed++; $display("FAIL %s_out c%0d: retired %b count %0d expected %b %0d",
                                 name, c, bus.retired, bus.retire_count, e_ret, e_cnt);
      end
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (random_mode) begin
          if (a[u] || !bus.unit_valid[u]) begin
            bus.unit_valid[u] = 1'b0;
            if ($urandom % 2 == 1) new_req(u);
          end
        end else if (u == 1) begin
          if (a[u]) bus.unit_valid[u] = 1'b0;
          else if (!bus.unit_valid[u]) new_req(u);
        end else if (u != 3 && a[u]) begin
          new_req(u);
        end
      end
      bus.fast_valid = random_mode && ($urandom % 2 == 1);
      bus.fast_data  = $urandom;
      do begin
        bus.fast_id = id_t'($urandom % 8);
        clash = 1'b0;
        for (int u = 0; u < NUM_UNITS; u++)
          if (bus.unit_valid[u] && bus.unit_id[u] == bus.fast_id) clash = 1'b1;
      end while (clash);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset(); drive_idle(); drive_all_valid();
    #1; tests_run++;
    if (bus.unit_ack !== 4'b0011) begin
      tests_failed++; $display("FAIL mid_pre_ack: got %b expected 0011", bus.unit_ack);
    end
    tick();
    rst_n = 1'b0; #1; tests_run++;
    if (bus.unit_ack !== '0) begin
      tests_failed++; $display("FAIL mid_rst_ack: got %b expected 0000", bus.unit_ack);
    end
    tick(); tests_run++;
    if ({bus.retired, bus.retire_count} !== '0) begin
      tests_failed++; $display("FAIL mid_rst_out: retired %b count %0d expected 000 0", bus.retired, bus.retire_count);
    end
    rst_n = 1'b1; bus.unit_valid = '0; #1; tests_run++;
    if (bus.unit_ack !== '0) begin
      tests_failed++; $display("FAIL mid_idle_ack: got %b expected 0000", bus.unit_ack);
    end
    tick(); tests_run++;
    if ({bus.retired, bus.retire_count} !== '0) begin
      tests_failed++; $display("FAIL mid_post_out: retired %b count %0d expected 000 0", bus.retired, bus.retire_count);
    end
    drive_all_valid(); #1; tests_run++;
    if (bus.unit_ack !== 4'b0011) begin
      tests_failed++; $display("FAIL mid_ptr_ack: got %b expected 0011", bus.unit_ack);
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    test_reset();
    test_all_valid();
    test_single_wrap();
    test_fast_plus_shared();
    test_traffic("starve", 40, 1'b0);
    test_traffic("random", 300, 1'b1);
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/retire_port_arbiter.md
Name: retire_port_arbiter

Overview:
- Schedules completing instructions onto the register-file commit ports that feed the ID manager (retired[], ids_retiring[]).
- Port 0 is reserved for the single-cycle issue-time path (ALU).
- Ports 1..COMMIT_PORTS-1 are shared among NUM_UNITS multi-cycle units (load, mul, div, CSR, ...) using rotating-priority multi-grant arbitration.
- Outputs are registered; sits between the writeback units and the ID/metadata block.

Parameters:
- NUM_UNITS, 4, number of multi-cycle writeback requesters
- COMMIT_PORTS, 3, total commit ports; shared ports S = COMMIT_PORTS-1 (S >= 1, S <= NUM_UNITS)
- ID_W, 3, instruction ID width (log2 MAX_IDS)
- DATA_W, 32, result width
- CNT_W, 2, retire_count width; must hold COMMIT_PORTS

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- fast_valid  in  1  issue-time retire on port 0
- fast_id  in  ID_W  ID for port 0
- fast_data  in  DATA_W  result for port 0
- unit_valid  in  NUM_UNITS  per-unit completion request, held until acked
- unit_id  in  NUM_UNITS x ID_W  per-unit ID
- unit_data  in  NUM_UNITS x DATA_W  per-unit result
- unit_ack  out  NUM_UNITS  combinational grant; request consumed this cycle
- retired  out  COMMIT_PORTS  registered port-valid bits
- ids_retiring  out  COMMIT_PORTS x ID_W  registered IDs
- retired_data  out  COMMIT_PORTS x DATA_W  registered results
- retire_count  out  CNT_W  registered popcount of retired

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous and active-low: rst_n sampled low at a clk edge resets the block.
  - Reset values: retired=0, ids_retiring=0, retired_data=0, retire_count=0, rr_ptr=0.
  - unit_ack is forced 0 while rst_n=0.
- Port 0:
  - retired[0], ids_retiring[0] and retired_data[0] load fast_valid/fast_id/fast_data every cycle.
  - No backpressure; latency 1.
- Shared-port arbitration, each cycle:
  - Scan units in order rr_ptr, rr_ptr+1, ... mod NUM_UNITS.
  - The first S units with unit_valid=1 are granted: unit_ack=1.
  - The k-th granted unit (k=0..S-1) is placed on port 1+k, registered next edge.
  - Ports with no grant load retired=0; their ID/data hold previous values (don't-care).
- Pointer update:
  - If at least one grant, rr_ptr <= (index of last granted unit + 1) mod NUM_UNITS.
  - If no grant, rr_ptr holds.
- Fairness guarantee: a continuously requesting unit is granted within ceil(NUM_UNITS/S) cycles.
- Handshake:
  - Units hold valid/id/data stable until ack.
  - Units may deassert valid only after ack.
  - The ack is same-cycle combinational, so a unit may present a new request the cycle after ack.
  - unit_ack never asserts without unit_valid.
- retire_count is registered in the same cycle as retired and equals popcount of next retired.
- Boundary conditions:
  - All units valid: exactly S acks, rotating.
  - Fewer than S valid: all granted, upper ports idle.
  - NUM_UNITS==S: all valid units are granted every cycle and the pointer is irrelevant.
  - rr_ptr wraps from NUM_UNITS-1 to 0.
  - fast path and shared ports are independent; they may all fire in the same cycle.
  - A duplicate ID across ports is a protocol error (assertion, no correction).
- Reset mid-operation: in-flight registered outputs are discarded and pending requests are not acked. Units must drop valid on reset; global control guarantees this.

Assertions:
- unit_ack & ~unit_valid never occurs.
- popcount(unit_ack) <= S.
- A valid unit's ID is stable until ack.

Decomposition:
- Shared package (taiga_types / taiga_config):
  - id_t
  - COMMIT_PORTS
  - NUM_WB_UNITS
  - a wb_request_t struct {id, data}
- Sub-module: rotating_priority_picker.
  - Combinational.
  - Inputs: request vector, rr_ptr.
  - Outputs: S one-hot grant vectors (one per port), combined ack vector, last-granted index.
  - Implementation: double-width request vector, shifted by rr_ptr, iterated S times with clear-lowest-set.
- Top level holds rr_ptr, the output registers and the count.

Test Plan (NUM_UNITS=4, COMMIT_PORTS=3, S=2):
- Reset: hold rst_n=0 for 2 cycles with all unit_valid=1 -> unit_ack=0000, retired=000, retire_count=0; after release, first cycle acks units 0,1.
- All four units valid continuously, IDs 4..7 -> acks {0,1},{2,3},{0,1}; ports 1/2 carry IDs 4/5 then 6/7 one cycle after each ack; retire_count=2 each cycle.
- Single request, unit 3 valid with ID 2 (rr_ptr=0) -> ack unit 3 same cycle; next cycle retired=010, ids_retiring[1]=2, rr_ptr=0 (wrap).
- fast_valid=1 (ID 1, data 0xDEAD) plus units 1,2 valid -> next cycle retired=111, port0 ID 1 / data 0xDEAD, ports 1/2 carry units 1/2, retire_count=3.
- Starvation check, units 0 and 2 always valid, unit 1 toggling -> every valid unit acked within 2 cycles; a unit's valid/ID are never dropped before ack.
- Reset mid-stream after an ack cycle -> retired cleared at the reset edge, rr_ptr=0, and no output from the pre-reset grant appears after rst_n rises.
